// File: rtl/button_pkg.sv
// Shared types and widths for the debounced button reader.
// The long-press feature is enabled by defining BUTTON_READER_LONGPRESS_EN.
package button_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 32;
  localparam int PCOUNT_W    = 8;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for an asynchronous board input, with a selectable
// reset level so the pin reads as idle while in reset.
import button_pkg::*;

module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: synchronizer, debounce FSM, press/release/long
// pulses and a wrapping press counter. Long press needs BUTTON_READER_LONGPRESS_EN.
//
// state        | meaning
// RELEASED     | button idle, waiting for an active sample
// PRESS_WAIT   | active level seen, counting debounce cycles
// HELD         | press accepted; long-press timer runs (if enabled)
// RELEASE_WAIT | inactive level seen, counting debounce cycles
import button_pkg::*;

module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned LONG_CYCLES     = 12_000_000,
  parameter bit          ACTIVE_LEVEL    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                btn_i,
  output logic                pressed_o,
  output logic                press_pulse_o,
  output logic                release_pulse_o,
  output logic                long_pulse_o,
  output logic [PCOUNT_W-1:0] press_count_o
);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_CYCLES == 0) begin : g_bad_long
    $error("LONG_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic sync_lvl;
  logic act;

  sync_2ff #(.RST_VAL(~ACTIVE_LEVEL)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (btn_i),
    .q_o     (sync_lvl)
  );

  assign act = (sync_lvl == ACTIVE_LEVEL);

  btn_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pressed_q, pressed_d;
  logic                press_pulse_q, press_pulse_d;
  logic                release_pulse_q, release_pulse_d;
  logic [PCOUNT_W-1:0] pcount_q, pcount_d;

`ifdef BUTTON_READER_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);

  // long_done_q keeps the saturated timer from re-firing within one hold
  logic long_pulse_q, long_pulse_d;
  logic long_done_q, long_done_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      long_pulse_q <= 1'b0;
      long_done_q  <= 1'b0;
    end else begin
      long_pulse_q <= long_pulse_d;
      long_done_q  <= long_done_d;
    end
  end

  assign long_pulse_o = long_pulse_q;
`else
  assign long_pulse_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= RELEASED;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      pcount_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      pcount_q        <= pcount_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    pcount_d        = pcount_q;
`ifdef BUTTON_READER_LONGPRESS_EN
    long_pulse_d    = 1'b0;
    long_done_d     = long_done_q;
`endif
    case (state_q)
      RELEASED: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
          pressed_d     = 1'b1;
          pcount_d      = pcount_q + 1'b1;
`ifdef BUTTON_READER_LONGPRESS_EN
          long_done_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!act) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BUTTON_READER_LONGPRESS_EN
        else if (cnt_q == LONG_LAST) begin
          if (!long_done_q) begin
            long_pulse_d = 1'b1;
            long_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_d = HELD;
          cnt_d   = '0;
`ifdef BUTTON_READER_LONGPRESS_EN
          long_done_d = 1'b0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d         = RELEASED;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
          pressed_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_pulse_q;
  assign release_pulse_o = release_pulse_q;
  assign press_count_o   = pcount_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: a run-length reference model predicts
// pulse events; a negedge monitor pops and compares them against the DUT.
module tb_button_reader;

  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef BUTTON_READER_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       pressed, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  button_reader #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .ACTIVE_LEVEL    (1'b1)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .btn_i           (btn),
    .pressed_o       (pressed),
    .press_pulse_o   (press_pulse),
    .release_pulse_o (release_pulse),
    .long_pulse_o    (long_pulse),
    .press_count_o   (press_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int cnt;
    int stamp;
  } ev_t;
  ev_t evq[$];

  // reference model state: pin history, debounced level, run of disagreeing
  // samples, cycles held since (re)entering the held level, press count
  int edge_n = 0;
  bit h1 = 0, h2 = 0, lvl = 0, fired = 0;
  int run = 0, hold = 0, pcnt = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  task automatic push(input int kind);
    ev_t e;
    e.kind  = kind;
    e.cnt   = pcnt;
    e.stamp = edge_n;
    evq.push_back(e);
  endtask

  initial begin
    bit a;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = 0; h2 = 0; lvl = 0; fired = 0;
        run = 0; hold = 0; pcnt = 0; edge_n = 0;
      end else begin
        edge_n++;
        a  = h2;
        h2 = h1;
        h1 = btn;
        if (a != lvl) begin
          run++;
          if (run == DEB + 1) begin
            lvl   = a;
            run   = 0;
            hold  = 0;
            fired = 0;
            if (lvl) begin
              pcnt = (pcnt + 1) % 256;
              push(K_PRESS);
            end else begin
              push(K_RELEASE);
            end
          end
        end else begin
          if (lvl && run != 0) begin
            hold  = 0;
            fired = 0;
          end else if (lvl && !fired) begin
            hold++;
            if (LONG_EN && hold == LONG) begin
              fired = 1;
              push(K_LONG);
            end
          end
          run = 0;
        end
      end
    end
  end

  initial begin
    ev_t e;
    int  np, dk;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("pressed_level", int'(pressed), int'(lvl));
        check("press_count_level", int'(press_count), pcnt);
        np = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
        dk = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_LONG);
        if (np > 1) check("pulse_exclusive", np, 1);
        if (np >= 1) begin
          if (evq.size() == 0) begin
            check("spurious_pulse", np, 0);
          end else begin
            e = evq.pop_front();
            check("pulse_kind", dk, e.kind);
            check("pulse_edge", edge_n, e.stamp);
            check("pulse_count", int'(press_count), e.cnt);
          end
        end else if (evq.size() > 0 && evq[0].stamp <= edge_n) begin
          e = evq.pop_front();
          check("missing_pulse", np, 1);
        end
      end
    end
  end

  task automatic drive(input bit v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pressed", int'(pressed), 0);
    check("rst_press_pulse", int'(press_pulse), 0);
    check("rst_release_pulse", int'(release_pulse), 0);
    check("rst_long_pulse", int'(long_pulse), 0);
    check("rst_press_count", int'(press_count), 0);
    repeat (hold_cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    btn   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("init_pressed", int'(pressed), 0);
    check("init_press_count", int'(press_count), 0);
    rst_n = 1'b1;

    // clean press and release
    drive(1, 15);
    check("s1_pressed", int'(pressed), 1);
    check("s1_count", int'(press_count), 1);
    drive(0, 15);
    check("s1_released", int'(pressed), 0);

    // bouncing, then settled press
    drive(1, 2); drive(0, 2); drive(1, 2); drive(0, 2);
    drive(1, 15);
    check("s2_count", int'(press_count), 2);
    drive(0, 15);

    // long hold
    drive(1, 30);
    drive(0, 15);
    check("s3_released", int'(pressed), 0);

    // wrap the press counter
    for (int i = 0; i < 256; i++) begin
      drive(1, 8);
      drive(0, 8);
    end
    check("s5_wrap_count", int'(press_count), 3);

    // reset in PRESS_WAIT, then in HELD, pin held active throughout
    drive(1, 4);
    do_reset(3);
    drive(1, 10);
    check("s6a_count", int'(press_count), 1);
    drive(1, 5);
    do_reset(2);
    drive(1, 12);
    check("s6b_count", int'(press_count), 1);
    drive(0, 15);

    // randomized pin activity with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 4));
      if ($urandom_range(0, 6) == 0) drive(1'($urandom_range(0, 1)), $urandom_range(20, 40));
      else drive(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    drive(0, 20);
    check("queue_drained", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
